shk_wr_cmd_gen: RTL

Parametrised shake-bus write-command engine: accepts one wide write transaction on a source shake slave, buffers its data words internally, then serialises a configurable number of address beats followed by all data (split into narrow beats, selectable byte order) onto a narrow destination shake master using a 4-phase ready handshake. It sits between the wide control-side shake fabric and narrow peripheral command links (sensor/ISP register buses), replacing external-BRAM staging with an internal buffer and adding error reporting.

---
 rtl/shk_wr_cmd_gen_if.sv | 35 +++
 rtl/shk_wr_cmd_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shk_wr_cmd_gen_if.sv
// Shake-bus bundle: master drives valid/msync/mdata/maddr,
// slave answers with ready/ssync/sdata/saddr.
//
// Ports (signals):
//   valid  - transaction active / beat present
//   msync  - data-word strobe / beat is data
//   mdata  - write word or data slice (DW bits)
//   maddr  - target address or beat tag (AW bits)
//   ready  - transaction done / beat acknowledge
//   ssync  - slave collecting words
//   sdata  - slave status data (DW bits)
//   saddr  - slave status address (AW bits)
interface shk_wr_cmd_gen_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          valid;
    logic          msync;
    logic [DW-1:0] mdata;
    logic [AW-1:0] maddr;
    logic          ready;
    logic          ssync;
    logic [DW-1:0] sdata;
    logic [AW-1:0] saddr;

    modport master (
        output valid, msync, mdata, maddr,
        input  ready, ssync, sdata, saddr
    );

    modport slave (
        input  valid, msync, mdata, maddr,
        output ready, ssync, sdata, saddr
    );
endinterface

// File: rtl/shk_wr_cmd_gen.sv
// Shake-bus write-command engine: buffers one wide write transaction and
// replays it as narrow address beats then data beats on a 4-phase link.
//
// Ports:
//   i_sys_clk, i_sys_resetn - clock, async active-low reset
//   s_shk_src   (slave)     - wide source transaction, words on msync
//   m_shk_dst   (master)    - narrow beats, msync=1 marks data beats
//   m_err_shk_info1         - sticky errors {abort, empty, timeout, ovf}
// Option: define SHK_WR_CMD_TIMEOUT_EN to give up on a beat after
// NB_TIMEOUT cycles without a ready edge.
module shk_wr_cmd_gen #(
    parameter int WD_SHK_DATA  = 32,
    parameter int WD_SHK_ADDR  = 32,
    parameter int WD_DST_DATA  = 8,
    parameter int NB_ADDR_BEAT = 2,
    parameter int DP_BUF       = 16,
    parameter int MD_MSB_FIRST = 1,
    parameter int NB_TIMEOUT   = 1024
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_resetn,
    shk_wr_cmd_gen_if.slave        s_shk_src,
    shk_wr_cmd_gen_if.master       m_shk_dst,
    output logic [3:0]             m_err_shk_info1
);
    localparam int NB_SLICE = WD_SHK_DATA / WD_DST_DATA;
    localparam int NB_DMAX  = DP_BUF * NB_SLICE;
    localparam int NB_BMAX  = (NB_DMAX > NB_ADDR_BEAT) ? NB_DMAX : NB_ADDR_BEAT;
    localparam int BW  = $clog2(NB_BMAX + 1);
    localparam int CW  = $clog2(DP_BUF + 1);
    localparam int AW  = (DP_BUF > 1) ? $clog2(DP_BUF) : 1;
    localparam int SW  = (NB_SLICE > 1) ? $clog2(NB_SLICE) : 1;
    localparam int ABW = (NB_ADDR_BEAT > 1) ? $clog2(NB_ADDR_BEAT) : 1;
    localparam int AL  = NB_ADDR_BEAT * WD_DST_DATA;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_DATA, S_REL, S_OVER
    } st_t;

    st_t                    state_q, state_d;
    logic                   r1_q, r2_q;
    logic                   valid_q, valid_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WD_SHK_ADDR-1:0] addr_q, addr_d;
    logic                   ssync_q, ssync_d;
    logic                   sready_q, sready_d;
    logic [3:0]             err_q, err_d;

    logic [WD_SHK_DATA-1:0] buf_q [DP_BUF];

    logic          pos, ack, busy, go, issue, tmo_hit;
    logic          wr_en, full, cnt_nz, last_addr, last_data;
    logic [BW-1:0] nbeats;

    // ready is registered once and edge-detected against a second stage
    assign pos   = r1_q & ~r2_q;
    assign ack   = valid_q & pos;
    assign busy  = (state_q == S_ADDR) | (state_q == S_DATA);
    assign go    = (state_q == S_START) & s_shk_src.valid;
    // a new beat only goes out once the previous ack has fully cleared
    assign issue = busy & ~valid_q & ~r1_q;

    assign full   = (count_q == CW'(DP_BUF));
    assign wr_en  = (state_q == S_ADDR) & s_shk_src.msync & ~full;
    // a word landing on the final address ack still counts
    assign cnt_nz = (count_q != '0) | wr_en;
    assign nbeats = BW'(count_q) * BW'(NB_SLICE);
    assign last_addr = (beat_q == BW'(NB_ADDR_BEAT - 1));
    assign last_data = ((beat_q + BW'(1)) == nbeats);

`ifdef SHK_WR_CMD_TIMEOUT_EN
    localparam int TW = $clog2(NB_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (go | issue) begin
            tmo_d = '0;
        end else if (valid_q) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = busy & valid_q & ~pos &
                     (tmo_q == TW'(NB_TIMEOUT - 1));
`else
    localparam int unused_nb_timeout = NB_TIMEOUT;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state_q  <= S_IDLE;
            r1_q     <= 1'b0;
            r2_q     <= 1'b0;
            valid_q  <= 1'b0;
            beat_q   <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            ssync_q  <= 1'b0;
            sready_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            r1_q     <= m_shk_dst.ready;
            r2_q     <= r1_q;
            valid_q  <= valid_d;
            beat_q   <= beat_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            ssync_q  <= ssync_d;
            sready_q <= sready_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (wr_en) begin
            buf_q[count_q[AW-1:0]] <= s_shk_src.mdata;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_START;
            S_START: if (s_shk_src.valid) state_d = S_ADDR;
            S_ADDR: begin
                if (ack && last_addr) begin
                    state_d = cnt_nz ? S_DATA : S_REL;
                end else if (tmo_hit) begin
                    state_d = S_REL;
                end
            end
            S_DATA: begin
                if ((ack && last_data) || tmo_hit) state_d = S_REL;
            end
            S_REL:   if (!s_shk_src.valid) state_d = S_OVER;
            S_OVER:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d  = valid_q;
        beat_d   = beat_q;
        count_d  = count_q;
        addr_d   = addr_q;
        ssync_d  = ssync_q;
        sready_d = sready_q;
        err_d    = err_q;
        if (wr_en) count_d = count_q + CW'(1);
        unique case (state_q)
            S_IDLE: sready_d = 1'b0;
            S_START: begin
                if (s_shk_src.valid) begin
                    addr_d  = s_shk_src.maddr;
                    ssync_d = 1'b1;
                    err_d   = '0;
                    count_d = '0;
                    valid_d = 1'b1;
                    beat_d  = '0;
                end
            end
            S_ADDR, S_DATA: begin
                if (!s_shk_src.valid) err_d[3] = 1'b1;
                if (s_shk_src.msync && (full || state_q == S_DATA)) begin
                    err_d[0] = 1'b1;
                end
                if (ack) begin
                    valid_d = 1'b0;
                    beat_d  = beat_q + BW'(1);
                    if (state_q == S_ADDR && last_addr) begin
                        beat_d = '0;
                        if (!cnt_nz) err_d[2] = 1'b1;
                    end
                end else if (tmo_hit) begin
                    valid_d  = 1'b0;
                    err_d[1] = 1'b1;
                end else if (issue) begin
                    valid_d = 1'b1;
                end
            end
            S_REL: begin
                ssync_d  = 1'b0;
                sready_d = 1'b1;
            end
            default: ;
        endcase
    end

    logic [NB_ADDR_BEAT-1:0][WD_DST_DATA-1:0] asl;
    logic [NB_SLICE-1:0][WD_DST_DATA-1:0]     wsl;
    logic [ABW-1:0]         aidx;
    logic [AW-1:0]          widx;
    logic [SW-1:0]          sidx;
    logic                   dst_msync;
    logic [WD_DST_DATA-1:0] dst_mdata, dst_maddr;

    // beat number -> address slice, word and slice within word
    assign aidx = (MD_MSB_FIRST != 0) ?
                  ABW'(NB_ADDR_BEAT - 1) - ABW'(beat_q) : ABW'(beat_q);
    assign widx = AW'(beat_q / BW'(NB_SLICE));
    assign sidx = (MD_MSB_FIRST != 0) ?
                  SW'(NB_SLICE - 1) - SW'(beat_q % BW'(NB_SLICE)) :
                  SW'(beat_q % BW'(NB_SLICE));
    assign asl  = addr_q[AL-1:0];
    assign wsl  = buf_q[widx];

    always_comb begin
        dst_msync = 1'b0;
        dst_mdata = '0;
        dst_maddr = '0;
        if (valid_q) begin
            unique case (1'b1)
                (state_q == S_ADDR): dst_maddr = asl[aidx];
                (state_q == S_DATA): begin
                    dst_msync = 1'b1;
                    dst_mdata = wsl[sidx];
                    dst_maddr = WD_DST_DATA'(beat_q);
                end
                default: ;
            endcase
        end
    end

    assign m_shk_dst.valid = valid_q;
    assign m_shk_dst.msync = dst_msync;
    assign m_shk_dst.mdata = dst_mdata;
    assign m_shk_dst.maddr = dst_maddr;

    assign s_shk_src.ready = sready_q;
    assign s_shk_src.ssync = ssync_q;
    assign s_shk_src.sdata = WD_SHK_DATA'(count_q);
    assign s_shk_src.saddr = addr_q;

    assign m_err_shk_info1 = err_q;

    wire unused_dst = ^{m_shk_dst.ssync, m_shk_dst.sdata, m_shk_dst.saddr};
endmodule
